// File: rtl/invmob2_if.sv
// Stream interface for the inverse Mobius engine: the vector input, the result
// output and the busy flag, grouped so the engine plugs in as one port.
interface invmob2_if #(
   parameter int N = 64
);

   logic [0:N-1] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [0:N-1] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   // The upstream/downstream side that feeds vectors and drains results.
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, busy
   );

   // The engine side.
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, busy
   );

endinterface

// File: rtl/invmob2.sv
// Iterative inverse Mobius transform over GF(2).
// Each RUN cycle applies one round: unshuffle (even bits to the lower half,
// odd bits to the upper half), then XOR the lower half into the upper half.
// After log2_N rounds every index bit has been folded exactly once and the
// rotation from the unshuffles has come back to identity, so d holds the
// truth table of the ANF vector that was accepted.
module invmob2 #(
   parameter int N      = 64,
   parameter int log2_N = 6
) (
   input logic     clk,
   input logic     rst,
   invmob2_if.slave bus
);

   localparam int CW = $clog2(log2_N + 1);

   // Reject parameter sets where the round count does not match the width.
   if (N < 2 || N != (1 << log2_N)) begin : g_bad_params
      $error("invmob2: N must be a power of two >= 2 and equal 2**log2_N");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic [0:N-1] d;
   logic [0:N-1] m;
   logic [0:N-1] d_next;
   logic [CW-1:0] cnt;

   // One round of the transform applied to the current contents of d.
   always_comb begin
      m      = '0;
      d_next = '0;
      for (int i = 0; i < N / 2; i++) begin
         m[i]       = d[2 * i];
         m[i + N/2] = d[2 * i + 1];
      end
      for (int i = 0; i < N / 2; i++) begin
         d_next[i]       = m[i];
         d_next[i + N/2] = m[i + N/2] ^ m[i];
      end
   end

   // Control FSM and data register: accept in IDLE, round in RUN, hold in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         d     <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  d     <= bus.in_data;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               d   <= d_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(log2_N - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state == RUN);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = d;

endmodule
